// File: rtl/matmul_stream_pkg.sv
// Shared definitions for the matmul operand streaming blocks.
package matmul_stream_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  // Counter width for a counter that spans 0..range-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/fixed_matmul_operand_replay_wrap_counter.sv
// Modulo-MAX up-counter with a one-cycle wrap strobe on the terminal increment.
module wrap_counter
  import matmul_stream_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == W'(MAX - 1));
  assign wrap     = inc & w_at_max;
  assign count    = r_count;

  // Advance on inc, returning to zero after MAX-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_at_max ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/fixed_matmul_operand_replay.sv
// Captures one IN_DEPTH-beat operand tile, then replays it REPEAT times
// toward the matmul data_in1 port before accepting the next tile.
module fixed_matmul_operand_replay
  import matmul_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned IN_SIZE     = 3,
  parameter int unsigned IN_DEPTH    = 3,
  parameter int unsigned REPEAT      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [PARALLELISM*IN_SIZE],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [PARALLELISM*IN_SIZE],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last_beat,
  output logic                  data_out_last
);

  localparam int unsigned N  = PARALLELISM * IN_SIZE;
  localparam int unsigned DW = cnt_width(IN_DEPTH);
  localparam int unsigned RW = cnt_width(REPEAT);

  stream_state_e         r_state;
  stream_state_e         w_state_nxt;
  logic [DATA_WIDTH-1:0] r_buf [IN_DEPTH][N];

  logic          w_stream;
  logic          w_load_hs;
  logic          w_out_hs;
  logic [DW-1:0] w_wr_cnt;
  logic [DW-1:0] w_rd_cnt;
  logic [RW-1:0] w_rep_cnt;
  logic          w_wr_wrap;
  logic          w_rd_wrap;
  logic          w_rep_wrap;

  assign w_stream  = (r_state == STREAM);
  assign w_load_hs = !w_stream & data_in_valid;
  assign w_out_hs  = w_stream & data_out_ready;

  wrap_counter #(.MAX(IN_DEPTH), .W(DW)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_load_hs),
    .count (w_wr_cnt),
    .wrap  (w_wr_wrap)
  );

  wrap_counter #(.MAX(IN_DEPTH), .W(DW)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_out_hs),
    .count (w_rd_cnt),
    .wrap  (w_rd_wrap)
  );

  // Pass counter steps once per completed pass; its wrap coincides with the
  // final beat, so both read counters land on zero without a separate clear.
  wrap_counter #(.MAX(REPEAT), .W(RW)) u_rep_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_rd_wrap),
    .count (w_rep_cnt),
    .wrap  (w_rep_wrap)
  );

  // Tile storage; intentionally not reset, stale slots are never read after a reset.
  always_ff @(posedge clk) begin
    if (w_load_hs) begin
      r_buf[w_wr_cnt] <= data_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave LOAD after the last load beat, leave STREAM after the last pass.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_wr_wrap)               w_state_nxt = STREAM;
      STREAM:  if (w_rd_wrap && w_rep_wrap) w_state_nxt = LOAD;
      default:                              w_state_nxt = LOAD;
    endcase
  end

  // Outputs are decoded from registered state, so reset clears them immediately.
  always_comb begin
    data_in_ready      = !w_stream;
    data_out_valid     = w_stream;
    data_out_last_beat = w_stream && (w_rd_cnt == DW'(IN_DEPTH - 1));
    data_out_last      = data_out_last_beat && (w_rep_cnt == RW'(REPEAT - 1));
    for (int unsigned e = 0; e < N; e++) begin
      data_out[e] = w_stream ? r_buf[w_rd_cnt][e] : '0;
    end
  end

endmodule

// File: tb/tb_fixed_matmul_operand_replay.sv
// Self-checking bench for fixed_matmul_operand_replay against a tile/pass model.
module tb_fixed_matmul_operand_replay;

  localparam int D  = 3;
  localparam int R  = 5;
  localparam int N  = 12;
  localparam int PW = N * 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] din  [N];
  logic [31:0] dout [N];
  logic        din_v, din_r, dout_v, dout_r, dout_lb, dout_l;

  logic [31:0] s_din  [N];
  logic [31:0] s_dout [N];
  logic        s_din_v, s_din_r, s_dout_v, s_dout_r, s_dout_lb, s_dout_l;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: either collecting beats of a tile, or emitting output beat j of D*R.
  logic [PW-1:0] m_tile [D];
  bit            m_loading;
  int            m_k, m_j;

  fixed_matmul_operand_replay #(
    .DATA_WIDTH(32), .PARALLELISM(4), .IN_SIZE(3), .IN_DEPTH(D), .REPEAT(R)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(din_v), .data_in_ready(din_r),
    .data_out(dout), .data_out_valid(dout_v), .data_out_ready(dout_r),
    .data_out_last_beat(dout_lb), .data_out_last(dout_l)
  );

  fixed_matmul_operand_replay #(
    .DATA_WIDTH(32), .PARALLELISM(4), .IN_SIZE(3), .IN_DEPTH(1), .REPEAT(1)
  ) dut_small (
    .clk(clk), .rst(rst),
    .data_in(s_din), .data_in_valid(s_din_v), .data_in_ready(s_din_r),
    .data_out(s_dout), .data_out_valid(s_dout_v), .data_out_ready(s_dout_r),
    .data_out_last_beat(s_dout_lb), .data_out_last(s_dout_l)
  );

  task automatic check_eq(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pack(input logic [31:0] a [N]);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*32 +: 32] = a[i];
    return p;
  endfunction

  task automatic model_reset();
    m_loading = 1'b1;
    m_k = 0;
    m_j = 0;
  endtask

  task automatic set_tile_beat(input int b, input int base);
    for (int i = 0; i < N; i++) din[i] = 32'(b * 100 + i + base);
  endtask

  task automatic set_random_beat();
    for (int i = 0; i < N; i++) din[i] = $urandom;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic [PW-1:0] exp_d, cap;
    bit hs_in, hs_out, exp_lb, exp_l;
    @(negedge clk);
    exp_d  = m_loading ? '0 : m_tile[m_j % D];
    exp_lb = !m_loading && ((m_j % D) == D - 1);
    exp_l  = !m_loading && (m_j == D * R - 1);
    check_eq("in_ready",  PW'(din_r),  PW'(m_loading));
    check_eq("out_valid", PW'(dout_v), PW'(!m_loading));
    check_eq("data_out",  pack(dout),  exp_d);
    check_eq("last_beat", PW'(dout_lb), PW'(exp_lb));
    check_eq("last",      PW'(dout_l),  PW'(exp_l));
    hs_in  = m_loading && din_v;
    hs_out = !m_loading && dout_r;
    cap    = pack(din);
    @(posedge clk);
    if (hs_in) begin
      m_tile[m_k] = cap;
      m_k++;
      if (m_k == D) begin
        m_k = 0;
        m_j = 0;
        m_loading = 1'b0;
      end
    end else if (hs_out) begin
      m_j++;
      if (m_j == D * R) begin
        m_j = 0;
        m_loading = 1'b1;
      end
    end
    #1;
  endtask

  // Called just after a rising edge: reset must take effect before the next edge.
  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    check_eq("rst_async_valid", PW'(dout_v),  PW'(0));
    check_eq("rst_async_ready", PW'(din_r),   PW'(1));
    check_eq("rst_async_data",  pack(dout),   '0);
    check_eq("rst_async_flags", PW'({dout_lb, dout_l}), PW'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic load_tile(input int base);
    din_v = 1'b1;
    for (int b = 0; b < D; b++) begin
      set_tile_beat(b, base);
      cycle();
    end
    din_v = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] s_exp;
    rst = 1'b0;
    din_v = 1'b0; dout_r = 1'b0;
    s_din_v = 1'b0; s_dout_r = 1'b0;
    for (int i = 0; i < N; i++) begin
      din[i] = '0;
      s_din[i] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;
    check_eq("reset_ready", PW'(din_r),  PW'(1));
    check_eq("reset_valid", PW'(dout_v), PW'(0));
    check_eq("reset_data",  pack(dout),  '0);
    check_eq("reset_flags", PW'({dout_lb, dout_l}), PW'(0));
    check_eq("reset_small_ready", PW'(s_din_r), PW'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic tile, consumer always ready.
    dout_r = 1'b1;
    load_tile(0);
    repeat (D * R + 2) cycle();

    // Consumer stalls every other cycle.
    load_tile(0);
    for (int c = 0; c < 2 * D * R; c++) begin
      dout_r = (c % 2 == 0);
      cycle();
    end
    dout_r = 1'b1;
    repeat (2) cycle();

    // Producer keeps valid high across the turnaround and through the stream.
    din_v = 1'b1;
    for (int c = 0; c < 2 * (D + D * R) + 4; c++) begin
      set_random_beat();
      cycle();
    end
    din_v = 1'b0;
    while (!m_loading) cycle();

    // Reset after a partial load, then a fresh tile.
    din_v = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) din[i] = 32'hAAAA_0000 + 32'(b * 16 + i);
      cycle();
    end
    din_v = 1'b0;
    pulse_reset();
    load_tile(7);
    repeat (D * R + 2) cycle();

    // Reset in the middle of a stream.
    load_tile(3000);
    repeat (4) cycle();
    pulse_reset();
    repeat (3) cycle();

    // Random traffic on both handshakes.
    for (int c = 0; c < 900; c++) begin
      din_v  = ($urandom_range(0, 3) != 0);
      dout_r = ($urandom_range(0, 3) != 0);
      set_random_beat();
      cycle();
    end
    din_v = 1'b0;
    dout_r = 1'b0;

    // Degenerate depth/repeat: one load beat yields one output beat.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) s_din[i] = $urandom;
      if (t == 0) s_din[0] = 32'hDEAD_BEEF;
      s_exp = pack(s_din);
      s_din_v = 1'b1;
      s_dout_r = 1'b1;
      @(negedge clk);
      check_eq("small_load_ready", PW'(s_din_r),  PW'(1));
      check_eq("small_load_valid", PW'(s_dout_v), PW'(0));
      @(posedge clk);
      #1;
      s_din_v = 1'b0;
      for (int i = 0; i < N; i++) s_din[i] = '0;
      @(negedge clk);
      check_eq("small_out_valid", PW'(s_dout_v), PW'(1));
      check_eq("small_out_ready", PW'(s_din_r),  PW'(0));
      check_eq("small_out_data",  pack(s_dout),  s_exp);
      check_eq("small_out_flags", PW'({s_dout_lb, s_dout_l}), PW'(2'b11));
      if (t == 0) check_eq("small_deadbeef", PW'(s_dout[0]), PW'(32'hDEAD_BEEF));
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("small_after_ready", PW'(s_din_r),  PW'(1));
      check_eq("small_after_valid", PW'(s_dout_v), PW'(0));
      check_eq("small_after_data",  pack(s_dout),  '0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_matmul_operand_replay.md
FIXED_MATMUL_OPERAND_REPLAY -- requirements
Module: fixed_matmul_operand_replay

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per element.
REQ-002 Parameter PARALLELISM, default 4: rows per beat; matches the consumer's IN1_PARALLELISM.
REQ-003 Parameter IN_SIZE, default 3: elements per row per beat.
REQ-004 Parameter IN_DEPTH, default 3: beats per tile pass.
REQ-005 Parameter REPEAT, default 5: tile passes emitted per load (one per weight column block); minimum 1.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  asynchronous reset, active-low.
REQ-008 data_in  input  DATA_WIDTH x (PARALLELISM*IN_SIZE) unpacked  load beat, row-major (row i in elements [i*IN_SIZE +: IN_SIZE]).
REQ-009 data_in_valid  input  1 / data_in_ready  output  1  load handshake.
REQ-010 data_out  output  DATA_WIDTH x (PARALLELISM*IN_SIZE) unpacked  replay beat, same layout as data_in.
REQ-011 data_out_valid  output  1 / data_out_ready  input  1  replay handshake, drives the matmul data_in1 port.
REQ-012 data_out_last_beat  output  1  high with the final beat (index IN_DEPTH-1) of each pass.
REQ-013 data_out_last  output  1  high with the final beat of the final pass.

Function
REQ-014 The FSM SHALL have exactly two states: LOAD and STREAM.
REQ-015 In LOAD, data_in_ready SHALL be 1 and data_out_valid SHALL be 0; in STREAM, data_in_ready SHALL be 0.
REQ-016 Each LOAD handshake (valid&ready) SHALL write data_in into buffer slot wr_cnt, then increment wr_cnt.
REQ-017 The handshake at wr_cnt=IN_DEPTH-1 SHALL wrap wr_cnt to 0 and move to STREAM on the next edge.
REQ-018 In STREAM, data_out_valid SHALL be 1 and data_out SHALL equal buffer[rd_cnt]; first valid beat appears in the cycle after the last load handshake (1-cycle turnaround).
REQ-019 Each STREAM handshake SHALL increment rd_cnt; at IN_DEPTH-1 rd_cnt wraps to 0 and rep_cnt increments.
REQ-020 The handshake with rd_cnt=IN_DEPTH-1 and rep_cnt=REPEAT-1 SHALL clear both counters and return to LOAD; data_in_ready is 1 the next cycle.
REQ-021 While data_out_valid=1 and data_out_ready=0, data_out, data_out_last_beat and data_out_last SHALL hold stable.
REQ-022 data_out_last_beat = STREAM & rd_cnt==IN_DEPTH-1; data_out_last = data_out_last_beat & rep_cnt==REPEAT-1.
REQ-023 When data_out_valid=0, data_out SHALL be all zeros and both last flags SHALL be 0.
REQ-024 IN_DEPTH=1 and/or REPEAT=1 SHALL work; with both at 1 each load beat yields exactly one output beat.
REQ-025 Elements SHALL pass bit-exact; no arithmetic, sign or width change.
REQ-026 Sustained throughput SHALL be one beat per cycle in each state when the partner holds valid/ready high.
REQ-027 Counter widths SHALL be $clog2 of their range, minimum 1 bit.

Reset
REQ-028 rst=0 SHALL asynchronously force state=LOAD, wr_cnt=rd_cnt=rep_cnt=0, data_out_valid=0, data_in_ready=1 (held while rst=0), last flags 0, data_out zero.
REQ-029 Buffer contents SHALL NOT be reset; a reset mid-load or mid-stream discards the partial tile, and no stale beat is emitted afterwards.

Structure
REQ-030 The state enum (LOAD, STREAM) SHALL live in shared package matmul_stream_pkg.
REQ-031 A single sub-module wrap_counter (parameter MAX, inc input, count and wrap outputs, async active-low reset) SHALL implement all three counters.
REQ-032 The buffer SHALL be a register array of IN_DEPTH beats; no RAM macro.

Verification
REQ-033 Defaults, 3 load beats with elements = beat*100+index, ready always 1 -> 15 output beats in 3-beat order repeated 5x; last_beat on beats 2,5,8,11,14; last only on beat 14.
REQ-034 data_out_ready toggling 1-0 every cycle during STREAM -> data_out and flags stable on every stalled cycle; sequence identical to REQ-033.
REQ-035 data_in_valid held 1 across turnaround -> data_in_ready=0 for exactly 15 stream cycles, and the second tile is accepted starting the cycle after data_out_last handshake.
REQ-036 rst pulsed low after 2 of 3 load beats, then a full new tile loaded -> output contains only the new tile values.
REQ-037 IN_DEPTH=1, REPEAT=1, value 0xDEADBEEF in element 0 -> one beat 0xDEADBEEF with last_beat=last=1, then data_in_ready=1.
REQ-038 rst pulsed low mid-stream -> data_out_valid=0 and data_in_ready=1 asynchronously, before the next clock edge.
